// File: rtl/tcb_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : tcb_sched_pkg
// Purpose  : Shared types and constants for the TCB inference scheduler:
//            FSM state encoding, default widths, and the bit used to build
//            the all-ones prediction reported when the watchdog fires.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tcb_sched_pkg;

  localparam int DEF_IMG_W   = 1024;
  localparam int DEF_PRED_W  = 32;
  localparam int DEF_LABEL_W = 4;
  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_CNT_W   = 16;

  // Replicated to PRED_W bits to form the all-ones timeout marker, so the
  // marker stays all-ones whatever prediction width is configured.
  localparam logic C_TIMEOUT_MARKER_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } sched_state_e;

endpackage : tcb_sched_pkg

`default_nettype wire

// File: rtl/tcb_sat_counter.sv
//------------------------------------------------------------------------------
// Module   : tcb_sat_counter
// Purpose  : Up-counter with synchronous clear and increment enable that
//            sticks at its maximum value instead of wrapping.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous reset, active-low
//            clr   - synchronous clear to zero (wins over inc)
//            inc   - increment enable
//            count - current count
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tcb_sat_counter
  import tcb_sched_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : tcb_sat_counter

`default_nettype wire

// File: rtl/tcb_infer_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tcb_infer_scheduler
// Purpose  : Sequencer in front of the TCB inference network. Accepts one
//            image + label, launches the network with a one-cycle pulse,
//            waits for the network's done pulse (or a watchdog expiry), and
//            presents the prediction on a valid/ready result stream.
// Ports    : clk, rst (sync, active-low)
//            s_valid/s_ready/s_img/s_label        - image input stream
//            net_img/net_valid/net_ready/net_number - network interface
//            r_valid/r_ready/r_number/r_label/r_timeout - result stream
//            busy       - state is not IDLE
//            img_count  - saturating count of delivered results
//            correct_count (only with TCB_SCHED_ACC_CNT_EN) - saturating
//                         count of non-timeout results matching the label
// Options  : define TCB_SCHED_ACC_CNT_EN to add the correct_count port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tcb_infer_scheduler
  import tcb_sched_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int PRED_W  = DEF_PRED_W,
  parameter int LABEL_W = DEF_LABEL_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IMG_W-1:0]   s_img,
  input  logic [LABEL_W-1:0] s_label,
  output logic [IMG_W-1:0]   net_img,
  output logic               net_valid,
  input  logic               net_ready,
  input  logic [PRED_W-1:0]  net_number,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [PRED_W-1:0]  r_number,
  output logic [LABEL_W-1:0] r_label,
  output logic               r_timeout,
  output logic               busy,
  output logic [CNT_W-1:0]   img_count
`ifdef TCB_SCHED_ACC_CNT_EN
  ,
  output logic [CNT_W-1:0]   correct_count
`endif
);

  // Timer only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

  sched_state_e       state_q,     state_d;
  logic [IMG_W-1:0]   net_img_q,   net_img_d;
  logic [PRED_W-1:0]  r_number_q,  r_number_d;
  logic [LABEL_W-1:0] r_label_q,   r_label_d;
  logic               r_timeout_q, r_timeout_d;

  logic [TMR_W-1:0]   tmr_count;
  logic               tmr_clr;
  logic               tmr_inc;
  logic               tmr_expired;
  logic               res_handshake;

  //----------------------------------------------------------------------------
  // Watchdog timer: cleared while launching, counts every WAIT cycle. Its
  // value is stale outside WAIT but is only ever looked at in WAIT.
  //----------------------------------------------------------------------------
  assign tmr_clr     = (state_q == LAUNCH);
  assign tmr_inc     = (state_q == WAIT);
  assign tmr_expired = (tmr_count == C_TMR_LAST);

  tcb_sat_counter #(
    .WIDTH (TMR_W)
  ) u_wdog_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .count (tmr_count)
  );

  //----------------------------------------------------------------------------
  // FSM next-state and datapath capture
  //----------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    net_img_d   = net_img_q;
    r_number_d  = r_number_q;
    r_label_d   = r_label_q;
    r_timeout_d = r_timeout_q;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          net_img_d = s_img;
          r_label_d = s_label;
          state_d   = LAUNCH;
        end
      end

      LAUNCH: begin
        state_d = WAIT;
      end

      WAIT: begin
        // A done pulse on the final timer count still counts as an answer.
        if (net_ready) begin
          r_number_d  = net_number;
          r_timeout_d = 1'b0;
          state_d     = HOLD;
        end else if (tmr_expired) begin
          r_number_d  = {PRED_W{C_TIMEOUT_MARKER_BIT}};
          r_timeout_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (r_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      net_img_q   <= '0;
      r_number_q  <= '0;
      r_label_q   <= '0;
      r_timeout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      net_img_q   <= net_img_d;
      r_number_q  <= r_number_d;
      r_label_q   <= r_label_d;
      r_timeout_q <= r_timeout_d;
    end
  end

  //----------------------------------------------------------------------------
  // Outputs decoded from state
  //----------------------------------------------------------------------------
  assign s_ready   = (state_q == IDLE);
  assign net_valid = (state_q == LAUNCH);
  assign r_valid   = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign net_img   = net_img_q;
  assign r_number  = r_number_q;
  assign r_label   = r_label_q;
  assign r_timeout = r_timeout_q;

  assign res_handshake = (state_q == HOLD) && r_ready;

  //----------------------------------------------------------------------------
  // Statistics
  //----------------------------------------------------------------------------
  tcb_sat_counter #(
    .WIDTH (CNT_W)
  ) u_img_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (res_handshake),
    .count (img_count)
  );

`ifdef TCB_SCHED_ACC_CNT_EN
  logic correct_inc;

  assign correct_inc = res_handshake && !r_timeout_q &&
                       (r_number_q == PRED_W'(r_label_q));

  tcb_sat_counter #(
    .WIDTH (CNT_W)
  ) u_correct_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (correct_inc),
    .count (correct_count)
  );
`endif

endmodule : tcb_infer_scheduler

`default_nettype wire

// File: tb/tb_tcb_infer_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_tcb_infer_scheduler
// Purpose  : Self-checking bench for tcb_infer_scheduler with a small
//            watchdog (16) and 4-bit statistics counters. Inputs change and
//            outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tcb_infer_scheduler;

  localparam int IMG_W   = 64;
  localparam int PRED_W  = 32;
  localparam int LABEL_W = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [IMG_W-1:0]   s_img = '0;
  logic [LABEL_W-1:0] s_label = '0;
  logic [IMG_W-1:0]   net_img;
  logic               net_valid;
  logic               net_ready = 1'b0;
  logic [PRED_W-1:0]  net_number = '0;
  logic               r_valid;
  logic               r_ready = 1'b0;
  logic [PRED_W-1:0]  r_number;
  logic [LABEL_W-1:0] r_label;
  logic               r_timeout;
  logic               busy;
  logic [CNT_W-1:0]   img_count;
`ifdef TCB_SCHED_ACC_CNT_EN
  logic [CNT_W-1:0]   correct_count;
`endif

  int tests = 0;
  int fails = 0;
  // Reference model: results delivered and correct results since reset.
  int m_imgs    = 0;
  int m_correct = 0;

  always #5 clk = ~clk;

  tcb_infer_scheduler #(
    .IMG_W   (IMG_W),
    .PRED_W  (PRED_W),
    .LABEL_W (LABEL_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_img      (s_img),
    .s_label    (s_label),
    .net_img    (net_img),
    .net_valid  (net_valid),
    .net_ready  (net_ready),
    .net_number (net_number),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_number   (r_number),
    .r_label    (r_label),
    .r_timeout  (r_timeout),
    .busy       (busy),
    .img_count  (img_count)
`ifdef TCB_SCHED_ACC_CNT_EN
    ,
    .correct_count (correct_count)
`endif
  );

  function automatic logic [IMG_W-1:0] rand_img();
    return {$urandom, $urandom};
  endfunction

  // One full transaction. Entered and left on a falling edge in IDLE.
  // lat: cycles after the launch cycle at which the network answers.
  task automatic run_image(input logic [IMG_W-1:0] img, input logic [LABEL_W-1:0] lbl,
                           input int lat, input bit respond, input logic [PRED_W-1:0] num,
                           input int hold, input bit stray);
    int                exp_t;
    logic [PRED_W-1:0] exp_num;
    bit                exp_to;
    int                got_t;
    int                pulses;
    bit                stable;

    if (respond && lat >= 1 && lat <= TIMEOUT) begin
      exp_t = lat + 1; exp_num = num; exp_to = 1'b0;
    end else begin
      exp_t = TIMEOUT + 1; exp_num = '1; exp_to = 1'b1;
    end

    tests++;
    if (s_ready !== 1'b1) begin
      fails++; $display("FAIL accept_ready: got %b expected 1", s_ready);
    end
    s_valid = 1'b1; s_img = img; s_label = lbl;
    @(negedge clk);
    s_valid = 1'b0; s_img = rand_img(); s_label = LABEL_W'($urandom);

    tests++;
    if (net_valid !== 1'b1 || net_img !== img || busy !== 1'b1) begin
      fails++;
      $display("FAIL launch: net_valid=%b net_img=%h busy=%b expected 1 %h 1",
               net_valid, net_img, busy, img);
    end

    pulses = 0; got_t = -1;
    for (int t = 1; t <= TIMEOUT + 8; t++) begin
      @(negedge clk);
      if (net_valid === 1'b1) pulses++;
      if (r_valid === 1'b1) begin
        got_t = t;
        break;
      end
      net_ready  = respond && (t == lat);
      net_number = net_ready ? num : $urandom;
    end
    net_ready = 1'b0;

    tests++;
    if (got_t != exp_t || pulses != 0) begin
      fails++;
      $display("FAIL result_latency: got cycle %0d (extra launch pulses %0d) expected cycle %0d (0)",
               got_t, pulses, exp_t);
    end
    tests++;
    if (r_number !== exp_num || r_label !== lbl || r_timeout !== exp_to ||
        s_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL result_data: got num=%h lbl=%h to=%b s_ready=%b busy=%b expected %h %h %b 0 1",
               r_number, r_label, r_timeout, s_ready, busy, exp_num, lbl, exp_to);
    end

    // Backpressure; optional stray network pulses and new images.
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (stray) begin
        net_ready = $urandom_range(0, 1) == 1; net_number = $urandom;
        s_valid   = 1'b1;                     s_img      = rand_img();
      end
      @(negedge clk);
      if (r_valid !== 1'b1 || r_number !== exp_num || r_label !== lbl ||
          r_timeout !== exp_to || s_ready !== 1'b0) stable = 1'b0;
    end
    net_ready = 1'b0; s_valid = 1'b0;
    if (hold > 0) begin
      tests++;
      if (!stable) begin
        fails++;
        $display("FAIL hold_stable: got r_valid=%b num=%h to=%b expected 1 %h %b",
                 r_valid, r_number, r_timeout, exp_num, exp_to);
      end
    end

    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    m_imgs++;
    if (!exp_to && exp_num == PRED_W'(lbl)) m_correct++;

    tests++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || net_img !== img ||
        img_count !== CNT_W'((m_imgs > CNT_MAX) ? CNT_MAX : m_imgs)) begin
      fails++;
      $display("FAIL after_handshake: got r_valid=%b s_ready=%b busy=%b img=%h cnt=%0d expected 0 1 0 %h %0d",
               r_valid, s_ready, busy, net_img, img_count, img,
               (m_imgs > CNT_MAX) ? CNT_MAX : m_imgs);
    end
`ifdef TCB_SCHED_ACC_CNT_EN
    tests++;
    if (correct_count !== CNT_W'((m_correct > CNT_MAX) ? CNT_MAX : m_correct)) begin
      fails++;
      $display("FAIL correct_count: got %0d expected %0d", correct_count,
               (m_correct > CNT_MAX) ? CNT_MAX : m_correct);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (s_ready !== 1'b1 || net_valid !== 1'b0 || r_valid !== 1'b0 || r_timeout !== 1'b0 ||
        busy !== 1'b0 || net_img !== '0 || r_number !== '0 || r_label !== '0 ||
        img_count !== '0) begin
      fails++;
      $display("FAIL reset_values: got s_ready=%b nv=%b rv=%b to=%b busy=%b img=%h num=%h lbl=%h cnt=%0d expected 1 0 0 0 0 0 0 0 0",
               s_ready, net_valid, r_valid, r_timeout, busy, net_img, r_number, r_label, img_count);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: got s_ready=%b busy=%b expected 1 0", s_ready, busy);
    end
    m_imgs = 0; m_correct = 0;
  endtask

  task automatic test_basic();
    run_image(64'hA5A5_0F0F_1234_5678, 4'd3, 10, 1'b1, 32'd3, 0, 1'b0);
  endtask

  task automatic test_timeout();
    // Never answers; late net_ready pulses and images arrive during HOLD.
    run_image(rand_img(), 4'd9, 0, 1'b0, 32'd0, 6, 1'b1);
  endtask

  task automatic test_backpressure();
    run_image(rand_img(), 4'd5, 4, 1'b1, 32'd5, 50, 1'b1);
    // Accepted straight after the single IDLE cycle.
    run_image(rand_img(), 4'd2, 1, 1'b1, 32'd8, 0, 1'b0);
  endtask

  task automatic test_tie();
    run_image(rand_img(), 4'd7, TIMEOUT, 1'b1, 32'd7, 0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    s_valid = 1'b1; s_img = rand_img(); s_label = 4'd6;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tests++;
    if (s_ready !== 1'b1 || net_valid !== 1'b0 || r_valid !== 1'b0 || busy !== 1'b0 ||
        net_img !== '0 || r_number !== '0 || r_label !== '0 || img_count !== '0) begin
      fails++;
      $display("FAIL reset_in_wait: got s_ready=%b rv=%b busy=%b img=%h num=%h cnt=%0d expected 1 0 0 0 0 0",
               s_ready, r_valid, busy, net_img, r_number, img_count);
    end
    m_imgs = 0; m_correct = 0;
    net_ready = 1'b1; net_number = 32'd6;
    @(negedge clk);
    net_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || r_valid !== 1'b0 || r_number !== '0) begin
      fails++;
      $display("FAIL stray_after_reset: got s_ready=%b busy=%b rv=%b num=%h expected 1 0 0 0",
               s_ready, busy, r_valid, r_number);
    end
  endtask

  task automatic test_random();
    logic [LABEL_W-1:0] lbl;
    logic [PRED_W-1:0]  num;
    int                 lat;
    bit                 resp;
    for (int i = 0; i < 20; i++) begin
      lbl  = LABEL_W'($urandom);
      num  = ($urandom_range(0, 2) != 0) ? PRED_W'(lbl) : PRED_W'($urandom_range(0, 15));
      lat  = $urandom_range(1, TIMEOUT + 3);
      resp = $urandom_range(0, 4) != 0;
      run_image(rand_img(), lbl, lat, resp, num, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_backpressure();
    test_tie();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_tcb_infer_scheduler

`default_nettype wire
